// File: rtl/pc_flag_if.sv
// Bus between the multicycle controller/ALU (master) and the PC/PSR stage (slave).
// Optional BRANCH_STATS_EN adds the branch-statistics counters to the bundle.
interface pc_flag_if #(
  parameter int WIDTH = 16
);
  // Strobes are single-cycle commands with no ready/valid back-pressure: the
  // controller asserts a strobe for exactly the cycle it wants the update,
  // the stage always accepts it at that posedge, and the result (pc/psr) is
  // visible from the following cycle.
  logic             pcAdd;
  logic             pcJump;
  logic             pcBranch;
  logic             flagWrite;
  logic [4:0]       aluFlags;
  logic [15:0]      instruction;
  logic [WIDTH-1:0] rTarget;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcPlus1;
  logic [4:0]       psr;
  logic             condTrue;
`ifdef BRANCH_STATS_EN
  logic [15:0]      takenCount;
  logic [15:0]      notTakenCount;

  modport master (
    output pcAdd, pcJump, pcBranch, flagWrite, aluFlags, instruction, rTarget,
    input  pc, pcPlus1, psr, condTrue, takenCount, notTakenCount
  );

  modport slave (
    input  pcAdd, pcJump, pcBranch, flagWrite, aluFlags, instruction, rTarget,
    output pc, pcPlus1, psr, condTrue, takenCount, notTakenCount
  );
`else
  modport master (
    output pcAdd, pcJump, pcBranch, flagWrite, aluFlags, instruction, rTarget,
    input  pc, pcPlus1, psr, condTrue
  );

  modport slave (
    input  pcAdd, pcJump, pcBranch, flagWrite, aluFlags, instruction, rTarget,
    output pc, pcPlus1, psr, condTrue
  );
`endif
endinterface

// File: rtl/pc_flag_unit.sv
// Program counter and PSR stage: condition evaluation, next-PC select, JAL link value.
// Define BRANCH_STATS_EN to add saturating taken / not-taken branch counters.
module pc_flag_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_flag_if.slave bus
);

  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_HI = 4'b0100,
    COND_LS = 4'b0101,
    COND_GT = 4'b0110,
    COND_LE = 4'b0111,
    COND_FS = 4'b1000,
    COND_FC = 4'b1001,
    COND_LO = 4'b1010,
    COND_HS = 4'b1011,
    COND_LT = 4'b1100,
    COND_GE = 4'b1101,
    COND_UC = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] disp_sext;
  logic [WIDTH-1:0] branch_target;
  logic [4:0]       psr_q;
  cond_e            cond;
  logic [7:0]       disp;
  logic             cond_true;
  logic             flag_c;
  logic             flag_l;
  logic             flag_f;
  logic             flag_z;
  logic             flag_n;
  logic             resolving;
  logic             unused_instr_hi;

  assign cond            = cond_e'(bus.instruction[11:8]);
  assign disp            = bus.instruction[7:0];
  assign unused_instr_hi = ^bus.instruction[15:12];

  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = psr_q;

  // Conditions read the registered PSR only, so a same-cycle flagWrite is not seen.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = !flag_z;
      COND_CS: cond_true = flag_c;
      COND_CC: cond_true = !flag_c;
      COND_HI: cond_true = flag_l;
      COND_LS: cond_true = !flag_l;
      COND_GT: cond_true = flag_n;
      COND_LE: cond_true = !flag_n;
      COND_FS: cond_true = flag_f;
      COND_FC: cond_true = !flag_f;
      COND_LO: cond_true = !flag_l && !flag_z;
      COND_HS: cond_true = flag_l || flag_z;
      COND_LT: cond_true = !flag_n && !flag_z;
      COND_GE: cond_true = flag_n || flag_z;
      COND_UC: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_inc        = pc_q + PC_ONE;
  assign disp_sext     = {{(WIDTH-8){disp[7]}}, disp};
  assign branch_target = pc_q + disp_sext;
  assign resolving     = bus.pcJump || bus.pcBranch;

  // Jump beats branch beats add when the controller overlaps strobes.
  always_comb begin
    pc_d = pc_q;
    if (bus.pcJump) begin
      pc_d = cond_true ? bus.rTarget : pc_inc;
    end else if (bus.pcBranch) begin
      pc_d = cond_true ? branch_target : pc_inc;
    end else if (bus.pcAdd) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      psr_q <= 5'b0;
    end else begin
      pc_q <= pc_d;
      if (bus.flagWrite) begin
        psr_q <= bus.aluFlags;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pcPlus1  = pc_inc;
  assign bus.psr      = psr_q;
  assign bus.condTrue = cond_true;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q;
  logic [15:0] not_taken_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_q     <= 16'h0000;
      not_taken_q <= 16'h0000;
    end else if (resolving) begin
      if (cond_true) begin
        if (taken_q != 16'hFFFF) taken_q <= taken_q + 16'h0001;
      end else begin
        if (not_taken_q != 16'hFFFF) not_taken_q <= not_taken_q + 16'h0001;
      end
    end
  end

  assign bus.takenCount    = taken_q;
  assign bus.notTakenCount = not_taken_q;
`else
  logic unused_resolving;
  assign unused_resolving = resolving;
`endif

endmodule
